// File: rtl/jt12_interpol_seq.sv
// Input sequencer for the FM/PSG interpolation FIR.
// A sample_in strobe latches NSRC stereo sources. Each source is then emitted
// in its own slot, followed by ZEROS zero-stuffed slots. Consecutive
// fir_sample strobes are SLOT_LEN clocks apart.
//
// Ports:
//   clk, rst         : clock and synchronous active-high reset
//   sample_in        : frame-start strobe
//   mute[NSRC]       : per-source mute, latched together with the samples
//   left_in/right_in : packed signed sources, source i at [i*W +: W]
//   fir_left/right   : slot data, held between strobes
//   fir_sample       : one-cycle strobe marking valid slot data
//   busy             : high from frame start through the frame_done cycle
//   overrun          : pulse when a sample_in is ignored
//   frame_done       : pulse when the last slot's wait expires
module jt12_interpol_seq #(
  parameter int W        = 9,
  parameter int NSRC     = 2,
  parameter int ZEROS    = 1,
  parameter int SLOT_LEN = 42
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sample_in,
  input  logic [NSRC-1:0]       mute,
  input  logic [NSRC*W-1:0]     left_in,
  input  logic [NSRC*W-1:0]     right_in,
  output logic signed [W-1:0]   fir_left,
  output logic signed [W-1:0]   fir_right,
  output logic                  fir_sample,
  output logic                  busy,
  output logic                  overrun,
  output logic                  frame_done
);

  localparam int NSLOT = NSRC * (ZEROS + 1);
  localparam int CNT_W = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;
  localparam int K_W   = (NSLOT > 1) ? $clog2(NSLOT) : 1;
  localparam int SRC_W = (NSRC > 1) ? $clog2(NSRC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_LEN - 1);
  localparam logic [K_W-1:0]   K_LAST   = K_W'(NSLOT - 1);

  typedef enum logic [1:0] {IDLE, EMIT, WAIT} state_t;

  state_t                     state;
  logic [K_W-1:0]             k;
  logic [CNT_W-1:0]           cnt;
  logic [NSRC*W-1:0]          shadow_l;
  logic [NSRC*W-1:0]          shadow_r;
  logic [NSRC-1:0]            shadow_mute;

  logic                       last_expiry;
  logic                       start;
  logic [SRC_W-1:0]           src;
  logic                       keep;
  logic signed [W-1:0]        slot_l;
  logic signed [W-1:0]        slot_r;

  // Pick source s out of a packed bank, or zero when the slot is stuffed/muted.
  function automatic logic signed [W-1:0] slot_pick(
    input logic [NSRC*W-1:0] bank,
    input logic [SRC_W-1:0]  s,
    input logic              sel
  );
    logic signed [W-1:0] v;
    v = '0;
    if (sel) v = bank[s*W +: W];
    return v;
  endfunction

  // A sample_in landing on the final WAIT expiry chains straight into a new
  // frame instead of being treated as an overrun.
  assign last_expiry = (state == WAIT) && (cnt == CNT_LAST) && (k == K_LAST);
  assign start       = sample_in && ((state == IDLE) || last_expiry);

  always_comb begin
    src    = SRC_W'(int'(k) / (ZEROS + 1));
    keep   = ((int'(k) % (ZEROS + 1)) == 0) && !shadow_mute[src];
    slot_l = slot_pick(shadow_l, src, keep);
    slot_r = slot_pick(shadow_r, src, keep);
  end

  // Shadow capture: decouples the emitted frame from later input changes.
  always_ff @(posedge clk) begin
    if (start) begin
      shadow_l    <= left_in;
      shadow_r    <= right_in;
      shadow_mute <= mute;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      k          <= '0;
      cnt        <= '0;
      fir_left   <= '0;
      fir_right  <= '0;
      fir_sample <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      fir_sample <= 1'b0;
      overrun    <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (sample_in) begin
            state <= EMIT;
            k     <= '0;
            busy  <= 1'b1;
          end else begin
            busy  <= 1'b0;
          end
        end
        EMIT: begin
          fir_left   <= slot_l;
          fir_right  <= slot_r;
          fir_sample <= 1'b1;
          cnt        <= CNT_W'(1);
          state      <= WAIT;
          overrun    <= sample_in;
        end
        WAIT: begin
          if (cnt == CNT_LAST) begin
            if (k != K_LAST) begin
              k       <= k + 1'b1;
              state   <= EMIT;
              overrun <= sample_in;
            end else begin
              // busy stays high for the frame_done cycle; IDLE clears it.
              frame_done <= 1'b1;
              if (sample_in) begin
                k     <= '0;
                state <= EMIT;
              end else begin
                state <= IDLE;
              end
            end
          end else begin
            cnt     <= cnt + 1'b1;
            overrun <= sample_in;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jt12_interpol_seq.sv
// Directed bench for jt12_interpol_seq: a default instance (2 sources,
// 1 zero, 42-clock slots) and a small instance (3 sources, no zeros,
// 4-clock slots). Times below are relative to the frame-start edge (rel 0).
module tb_jt12_interpol_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default instance
  logic              rst;
  logic              sample_in;
  logic [1:0]        mute;
  logic [17:0]       left_in;
  logic [17:0]       right_in;
  logic signed [8:0] fir_left;
  logic signed [8:0] fir_right;
  logic              fir_sample;
  logic              busy;
  logic              overrun;
  logic              frame_done;

  jt12_interpol_seq dut (
    .clk(clk), .rst(rst), .sample_in(sample_in), .mute(mute),
    .left_in(left_in), .right_in(right_in),
    .fir_left(fir_left), .fir_right(fir_right), .fir_sample(fir_sample),
    .busy(busy), .overrun(overrun), .frame_done(frame_done)
  );

  // Small instance
  logic              s_sample_in;
  logic [2:0]        s_mute;
  logic [26:0]       s_left_in;
  logic [26:0]       s_right_in;
  logic signed [8:0] s_fir_left;
  logic signed [8:0] s_fir_right;
  logic              s_fir_sample;
  logic              s_busy;
  logic              s_overrun;
  logic              s_frame_done;

  jt12_interpol_seq #(.W(9), .NSRC(3), .ZEROS(0), .SLOT_LEN(4)) dut_s (
    .clk(clk), .rst(rst), .sample_in(s_sample_in), .mute(s_mute),
    .left_in(s_left_in), .right_in(s_right_in),
    .fir_left(s_fir_left), .fir_right(s_fir_right), .fir_sample(s_fir_sample),
    .busy(s_busy), .overrun(s_overrun), .frame_done(s_frame_done)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Event record filled by observe()
  int          ns;
  int          st_rel [8];
  logic [17:0] st_d   [8];
  int          fd_rel, fd_cnt, ov_rel, ov_cnt, busy_low;
  logic        busy0;
  logic [21:0] rst_snap;

  localparam logic [17:0] L_A = {9'h0F0, 9'h055};
  localparam logic [17:0] R_A = {9'h10F, 9'h1AA};
  // Values applied right after the frame start; only a chained frame may see them.
  localparam logic [17:0] L_G = {9'h123, 9'h0AB};
  localparam logic [17:0] R_G = {9'h1C0, 9'h03C};

  task automatic do_reset();
    rst = 1'b1; sample_in = 1'b0; s_sample_in = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic start_frame(input logic [1:0] m);
    left_in = L_A; right_in = R_A; mute = m;
    sample_in = 1'b1;
    @(posedge clk);
    #1 sample_in = 1'b0;
    busy0 = busy;
  endtask

  task automatic observe(input int n, input int inject_at, input int rst_at);
    ns = 0; fd_rel = -1; fd_cnt = 0; ov_rel = -1; ov_cnt = 0; busy_low = -1;
    rst_snap = '1;
    for (int rel = 1; rel <= n; rel++) begin
      sample_in = (rel == inject_at);
      rst       = (rel == rst_at);
      @(posedge clk);
      #1;
      sample_in = 1'b0;
      rst       = 1'b0;
      if (rel == 1) begin
        left_in = L_G; right_in = R_G; mute = 2'b10;
      end
      if (fir_sample && ns < 8) begin
        st_rel[ns] = rel; st_d[ns] = {fir_left, fir_right}; ns++;
      end
      if (frame_done) begin fd_cnt++; if (fd_rel < 0) fd_rel = rel; end
      if (overrun)    begin ov_cnt++; if (ov_rel < 0) ov_rel = rel; end
      if (!busy && busy_low < 0) busy_low = rel;
      if (rel == rst_at)
        rst_snap = {fir_left, fir_right, fir_sample, busy, overrun, frame_done};
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++;
    if ({fir_left, fir_right, fir_sample, busy, overrun, frame_done} !== 22'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h, want 000000", {fir_left, fir_right, fir_sample, busy, overrun, frame_done});
    end
    n_cmp++;
    if ({s_fir_left, s_fir_right, s_fir_sample, s_busy, s_overrun, s_frame_done} !== 22'h0) begin
      n_bad++;
      $display("FAIL reset_outputs_small: got %h, want 000000", {s_fir_left, s_fir_right, s_fir_sample, s_busy, s_overrun, s_frame_done});
    end
  endtask

  task automatic test_basic_frame();
    int          er [4] = '{1, 43, 85, 127};
    logic [17:0] ed [4] = '{{9'h055, 9'h1AA}, 18'h0, {9'h0F0, 9'h10F}, 18'h0};
    do_reset();
    start_frame(2'b00);
    observe(175, -1, -1);
    n_cmp++;
    if (busy0 !== 1'b1) begin n_bad++; $display("FAIL basic_busy_start: got %b, want 1", busy0); end
    n_cmp++;
    if (ns !== 4) begin n_bad++; $display("FAIL basic_strobe_count: got %0d, want 4", ns); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (st_rel[i] !== er[i] || st_d[i] !== ed[i]) begin
        n_bad++;
        $display("FAIL basic_slot%0d: got rel %0d data %h, want rel %0d data %h", i, st_rel[i], st_d[i], er[i], ed[i]);
      end
    end
    n_cmp++;
    if (fd_rel !== 168 || fd_cnt !== 1) begin
      n_bad++; $display("FAIL basic_frame_done: got rel %0d count %0d, want rel 168 count 1", fd_rel, fd_cnt);
    end
    n_cmp++;
    if (busy_low !== 169) begin n_bad++; $display("FAIL basic_busy_end: got first low %0d, want 169", busy_low); end
    n_cmp++;
    if (ov_cnt !== 0) begin n_bad++; $display("FAIL basic_overrun: got %0d pulses, want 0", ov_cnt); end
  endtask

  task automatic test_mute();
    do_reset();
    start_frame(2'b01);
    observe(170, -1, -1);
    n_cmp++;
    if (ns !== 4) begin n_bad++; $display("FAIL mute_strobe_count: got %0d, want 4", ns); end
    n_cmp++;
    if (st_d[0] !== 18'h0) begin n_bad++; $display("FAIL mute_slot0: got %h, want 00000", st_d[0]); end
    n_cmp++;
    if (st_d[2] !== {9'h0F0, 9'h10F}) begin
      n_bad++; $display("FAIL mute_slot2: got %h, want %h", st_d[2], {9'h0F0, 9'h10F});
    end
  endtask

  task automatic test_overrun();
    do_reset();
    start_frame(2'b00);
    observe(175, 50, -1);
    n_cmp++;
    if (ov_rel !== 50 || ov_cnt !== 1) begin
      n_bad++; $display("FAIL overrun_pulse: got rel %0d count %0d, want rel 50 count 1", ov_rel, ov_cnt);
    end
    n_cmp++;
    if (ns !== 4 || st_rel[2] !== 85 || st_d[2] !== {9'h0F0, 9'h10F}) begin
      n_bad++; $display("FAIL overrun_schedule: got %0d strobes, slot2 rel %0d data %h, want 4, 85, %h", ns, st_rel[2], st_d[2], {9'h0F0, 9'h10F});
    end
    n_cmp++;
    if (fd_rel !== 168) begin n_bad++; $display("FAIL overrun_frame_done: got rel %0d, want 168", fd_rel); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    start_frame(2'b00);
    observe(175, 168, -1);
    n_cmp++;
    if (fd_rel !== 168 || ov_cnt !== 0) begin
      n_bad++; $display("FAIL b2b_done: got frame_done rel %0d overruns %0d, want 168 and 0", fd_rel, ov_cnt);
    end
    n_cmp++;
    if (ns !== 5 || st_rel[4] !== 169 || st_d[4] !== {9'h0AB, 9'h03C}) begin
      n_bad++; $display("FAIL b2b_next_strobe: got %0d strobes, rel %0d data %h, want 5, 169, %h", ns, st_rel[4], st_d[4], {9'h0AB, 9'h03C});
    end
    n_cmp++;
    if (busy_low !== -1) begin n_bad++; $display("FAIL b2b_busy: got low at %0d, want never", busy_low); end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    start_frame(2'b00);
    observe(180, -1, 60);
    n_cmp++;
    if (rst_snap !== 22'h0) begin n_bad++; $display("FAIL midrst_outputs: got %h, want 000000", rst_snap); end
    n_cmp++;
    if (ns !== 2 || fd_cnt !== 0) begin
      n_bad++; $display("FAIL midrst_abandon: got %0d strobes %0d done, want 2 and 0", ns, fd_cnt);
    end
    start_frame(2'b00);
    observe(2, -1, -1);
    n_cmp++;
    if (ns !== 1 || st_d[0] !== {9'h055, 9'h1AA}) begin
      n_bad++; $display("FAIL midrst_restart: got %0d strobes data %h, want 1 and %h", ns, st_d[0], {9'h055, 9'h1AA});
    end
  endtask

  task automatic test_small_config();
    int          er [3] = '{1, 5, 9};
    logic [17:0] ed [3] = '{{9'h011, 9'h100}, {9'h022, 9'h0FF}, {9'h1F0, 9'h033}};
    int          sn, sfd, slow;
    int          sr [3];
    logic [17:0] sd [3];
    do_reset();
    s_left_in  = {9'h1F0, 9'h022, 9'h011};
    s_right_in = {9'h033, 9'h0FF, 9'h100};
    s_mute     = 3'b000;
    s_sample_in = 1'b1;
    @(posedge clk);
    #1 s_sample_in = 1'b0;
    s_left_in = '1; s_right_in = '1;
    sn = 0; sfd = -1; slow = -1;
    for (int rel = 1; rel <= 14; rel++) begin
      @(posedge clk);
      #1;
      if (s_fir_sample && sn < 3) begin sr[sn] = rel; sd[sn] = {s_fir_left, s_fir_right}; sn++; end
      if (s_frame_done && sfd < 0) sfd = rel;
      if (!s_busy && slow < 0) slow = rel;
    end
    n_cmp++;
    if (sn !== 3) begin n_bad++; $display("FAIL small_strobe_count: got %0d, want 3", sn); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (sr[i] !== er[i] || sd[i] !== ed[i]) begin
        n_bad++;
        $display("FAIL small_slot%0d: got rel %0d data %h, want rel %0d data %h", i, sr[i], sd[i], er[i], ed[i]);
      end
    end
    n_cmp++;
    if (sfd !== 12 || slow !== 13) begin
      n_bad++; $display("FAIL small_frame_done: got done %0d busy low %0d, want 12 and 13", sfd, slow);
    end
  endtask

  initial begin
    rst = 1'b1; sample_in = 1'b0; mute = '0; left_in = '0; right_in = '0;
    s_sample_in = 1'b0; s_mute = '0; s_left_in = '0; s_right_in = '0;
    test_reset();
    test_basic_frame();
    test_mute();
    test_overrun();
    test_back_to_back();
    test_reset_mid_frame();
    test_small_config();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
